// File: rtl/vga_sprite_renderer.sv
// vga_sprite_renderer
//   Pixel-colour stage that sits directly after the VGA timing controller.
//   It paints a checkerboard background and a square sprite that moves once per
//   frame and bounces off the screen edges. All colour outputs and all re-timed
//   sync/blank strobes have a fixed latency of 2 clocks.
//
// Ports
//   Clock       in   pixel clock
//   Reset_n     in   synchronous active-low reset
//   Run         in   1 = sprite steps on frame ticks, 0 = sprite frozen
//   blank_n     in   1 = active pixel
//   sync_n      in   composite sync from timing stage
//   hSync_n     in   horizontal sync from timing stage
//   vSync_n     in   vertical sync from timing stage (falling edge = frame tick)
//   nextX       in   pixel column (11 bits)
//   nextY       in   pixel row (10 bits)
//   Red/Green/Blue out  pixel colour, 8 bits per channel
//   blank_n_o, sync_n_o, hSync_n_o, vSync_n_o  out  input strobes delayed 2 clocks
//   FrameCount  out  frame ticks since reset, wraps at 16 bits
module vga_sprite_renderer #(
  parameter int          H_ACTIVE    = 800,
  parameter int          V_ACTIVE    = 600,
  parameter int          SPRITE_SIZE = 32,
  parameter int          STEP        = 2,
  parameter logic [23:0] SPRITE_RGB  = 24'hFF4000,
  parameter int          TILE_LOG2   = 6
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Run,
  input  logic        blank_n,
  input  logic        sync_n,
  input  logic        hSync_n,
  input  logic        vSync_n,
  input  logic [10:0] nextX,
  input  logic [9:0]  nextY,
  output logic [7:0]  Red,
  output logic [7:0]  Green,
  output logic [7:0]  Blue,
  output logic        blank_n_o,
  output logic        sync_n_o,
  output logic        hSync_n_o,
  output logic        vSync_n_o,
  output logic [15:0] FrameCount
);

  localparam logic [11:0] L_H    = 12'(H_ACTIVE);
  localparam logic [11:0] L_V    = 12'(V_ACTIVE);
  localparam logic [11:0] L_SIZE = 12'(SPRITE_SIZE);
  localparam logic [11:0] L_STEP = 12'(STEP);

  // Sprite top-left corner; kept 12 bits wide so every compare and step
  // is done in 12-bit unsigned arithmetic without any wrap.
  logic [11:0] r_sx;
  logic [11:0] r_sy;
  logic        r_dirXPos;
  logic        r_dirYPos;
  logic        r_vSyncPrev;

  // Stage-1 registers
  logic r_s1Blank;
  logic r_s1Sync;
  logic r_s1HSync;
  logic r_s1VSync;
  logic r_s1InSprite;
  logic r_s1Tile;

  logic [11:0] w_x;
  logic [11:0] w_y;
  logic        w_inSprite;
  logic        w_tile;
  logic        w_tick;
  logic [11:0] w_sxNext;
  logic [11:0] w_syNext;
  logic        w_dirXNext;
  logic        w_dirYNext;

  assign w_x = {1'b0, nextX};
  assign w_y = {2'b0, nextY};

  assign w_inSprite = (w_x >= r_sx) && (w_x <= r_sx + L_SIZE - 12'd1) &&
                      (w_y >= r_sy) && (w_y <= r_sy + L_SIZE - 12'd1);
  assign w_tile     = nextX[TILE_LOG2] ^ nextY[TILE_LOG2];

  // Frame tick is the one-cycle falling edge of vSync_n.
  assign w_tick = r_vSyncPrev & ~vSync_n;

  // Candidate sprite position after one step; a direction flips when the
  // sprite would cross an edge, and the sprite is clamped to that edge.
  always_comb begin
    w_sxNext   = r_sx;
    w_syNext   = r_sy;
    w_dirXNext = r_dirXPos;
    w_dirYNext = r_dirYPos;

    if (r_dirXPos) begin
      if (r_sx + L_STEP + L_SIZE > L_H) begin
        w_sxNext   = L_H - L_SIZE;
        w_dirXNext = 1'b0;
      end else begin
        w_sxNext = r_sx + L_STEP;
      end
    end else begin
      if (r_sx < L_STEP) begin
        w_sxNext   = 12'd0;
        w_dirXNext = 1'b1;
      end else begin
        w_sxNext = r_sx - L_STEP;
      end
    end

    if (r_dirYPos) begin
      if (r_sy + L_STEP + L_SIZE > L_V) begin
        w_syNext   = L_V - L_SIZE;
        w_dirYNext = 1'b0;
      end else begin
        w_syNext = r_sy + L_STEP;
      end
    end else begin
      if (r_sy < L_STEP) begin
        w_syNext   = 12'd0;
        w_dirYNext = 1'b1;
      end else begin
        w_syNext = r_sy - L_STEP;
      end
    end
  end

  // Frame counter and sprite motion; position only moves on a tick so a
  // visible frame is always drawn with a single sprite position.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_vSyncPrev <= 1'b0;
      FrameCount  <= 16'd0;
      r_sx        <= 12'd0;
      r_sy        <= 12'd0;
      r_dirXPos   <= 1'b1;
      r_dirYPos   <= 1'b1;
    end else begin
      r_vSyncPrev <= vSync_n;
      if (w_tick) begin
        FrameCount <= FrameCount + 16'd1;
        if (Run) begin
          r_sx      <= w_sxNext;
          r_sy      <= w_syNext;
          r_dirXPos <= w_dirXNext;
          r_dirYPos <= w_dirYNext;
        end
      end
    end
  end

  // Stage 1: capture strobes and per-pixel flags.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_s1Blank    <= 1'b0;
      r_s1Sync     <= 1'b1;
      r_s1HSync    <= 1'b1;
      r_s1VSync    <= 1'b1;
      r_s1InSprite <= 1'b0;
      r_s1Tile     <= 1'b0;
    end else begin
      r_s1Blank    <= blank_n;
      r_s1Sync     <= sync_n;
      r_s1HSync    <= hSync_n;
      r_s1VSync    <= vSync_n;
      r_s1InSprite <= w_inSprite;
      r_s1Tile     <= w_tile;
    end
  end

  // Stage 2: pick the colour and register every output.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      Red       <= 8'd0;
      Green     <= 8'd0;
      Blue      <= 8'd0;
      blank_n_o <= 1'b0;
      sync_n_o  <= 1'b1;
      hSync_n_o <= 1'b1;
      vSync_n_o <= 1'b1;
    end else begin
      blank_n_o <= r_s1Blank;
      sync_n_o  <= r_s1Sync;
      hSync_n_o <= r_s1HSync;
      vSync_n_o <= r_s1VSync;
      if (!r_s1Blank) begin
        {Red, Green, Blue} <= 24'd0;
      end else if (r_s1InSprite) begin
        {Red, Green, Blue} <= SPRITE_RGB;
      end else if (r_s1Tile) begin
        {Red, Green, Blue} <= 24'h606060;
      end else begin
        {Red, Green, Blue} <= 24'h202020;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_renderer.sv
// tb_vga_sprite_renderer
//   Self-checking bench for vga_sprite_renderer. A behavioural model tracks the
//   sprite position, direction and frame count with plain integer arithmetic and
//   predicts pixel colours from the screen rules.
module tb_vga_sprite_renderer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        Run;
  logic        blank_n;
  logic        sync_n;
  logic        hSync_n;
  logic        vSync_n;
  logic [10:0] nextX;
  logic [9:0]  nextY;
  logic [7:0]  Red;
  logic [7:0]  Green;
  logic [7:0]  Blue;
  logic        blank_n_o;
  logic        sync_n_o;
  logic        hSync_n_o;
  logic        vSync_n_o;
  logic [15:0] FrameCount;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int mx, my;
  bit mdx, mdy;
  int mfc;
  bit hitRight, hitLeft, hitBottom, hitTop;

  vga_sprite_renderer dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Run        (Run),
    .blank_n    (blank_n),
    .sync_n     (sync_n),
    .hSync_n    (hSync_n),
    .vSync_n    (vSync_n),
    .nextX      (nextX),
    .nextY      (nextY),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue),
    .blank_n_o  (blank_n_o),
    .sync_n_o   (sync_n_o),
    .hSync_n_o  (hSync_n_o),
    .vSync_n_o  (vSync_n_o),
    .FrameCount (FrameCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [23:0] refColour(input bit blank, input int x, input int y);
    if (!blank) return 24'h000000;
    if (x >= mx && x < mx + 32 && y >= my && y < my + 32) return 24'hFF4000;
    if ((((x / 64) + (y / 64)) % 2) == 1) return 24'h606060;
    return 24'h202020;
  endfunction

  function automatic void modelReset();
    mx = 0; my = 0; mdx = 1'b1; mdy = 1'b1; mfc = 0;
  endfunction

  function automatic void modelTick(input bit run);
    mfc = (mfc + 1) % 65536;
    if (!run) return;
    if (mdx) begin
      if (mx + 2 + 32 > 800) begin mx = 768; mdx = 1'b0; hitRight = 1'b1; end
      else mx = mx + 2;
    end else begin
      if (mx < 2) begin mx = 0; mdx = 1'b1; hitLeft = 1'b1; end
      else mx = mx - 2;
    end
    if (mdy) begin
      if (my + 2 + 32 > 600) begin my = 568; mdy = 1'b0; hitBottom = 1'b1; end
      else my = my + 2;
    end else begin
      if (my < 2) begin my = 0; mdy = 1'b1; hitTop = 1'b1; end
      else my = my - 2;
    end
  endfunction

  task automatic idleInputs();
    Run = 1'b0; blank_n = 1'b0; sync_n = 1'b1; hSync_n = 1'b1; vSync_n = 1'b1;
    nextX = 11'd0; nextY = 10'd0;
  endtask

  task automatic doReset();
    idleInputs();
    Reset_n = 1'b0;
    repeat (3) step();
    Reset_n = 1'b1;
    modelReset();
    step();
  endtask

  // Hold one active pixel for two clocks and compare the colour.
  task automatic probe(input int x, input int y, input string name);
    logic [23:0] got, exp;
    blank_n = 1'b1;
    nextX = x[10:0];
    nextY = y[9:0];
    step();
    step();
    exp = refColour(1'b1, x, y);
    got = {Red, Green, Blue};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s pixel(%0d,%0d) sprite@(%0d,%0d): got %h expected %h",
               name, x, y, mx, my, got, exp);
    end
  endtask

  // One vSync_n falling edge with Run held at the tick edge.
  task automatic frameTick(input bit run);
    Run = run;
    vSync_n = 1'b0;
    step();
    modelTick(run);
    vSync_n = 1'b1;
    Run = ~run;
    step();
    checks++;
    if (FrameCount !== mfc[15:0]) begin
      failures++;
      $display("[TB] FAIL frameCount: got %0d expected %0d", FrameCount, mfc);
    end
  endtask

  task automatic probeSprite(input string name);
    probe(mx, my, name);
    probe(mx + 31, my + 31, name);
    probe(mx + 32, my, name);
    probe(mx, my + 32, name);
    if (mx > 0) probe(mx - 1, my, name);
    if (my > 0) probe(mx, my - 1, name);
    probe($urandom_range(0, 799), $urandom_range(0, 599), name);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Run = 1'b1; blank_n = 1'b1; sync_n = 1'b0; hSync_n = 1'b0; vSync_n = 1'b0;
    nextX = 11'd5; nextY = 10'd5;
    repeat (3) step();
    checks++;
    if ({Red, Green, Blue} !== 24'd0 || blank_n_o !== 1'b0 || sync_n_o !== 1'b1 ||
        hSync_n_o !== 1'b1 || vSync_n_o !== 1'b1 || FrameCount !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_values: rgb=%h blank=%b sync=%b h=%b v=%b fc=%0d expected rgb=0 blank=0 syncs=1 fc=0",
               {Red, Green, Blue}, blank_n_o, sync_n_o, hSync_n_o, vSync_n_o, FrameCount);
    end
    modelReset();
    Reset_n = 1'b1; Run = 1'b0; sync_n = 1'b1; hSync_n = 1'b1; vSync_n = 1'b1;
    step();
    checks++;
    if ({Red, Green, Blue} !== 24'd0 || blank_n_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_latency1: rgb=%h blank=%b expected 000000/0",
               {Red, Green, Blue}, blank_n_o);
    end
    step();
    checks++;
    if ({Red, Green, Blue} !== 24'hFF4000 || blank_n_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_release_latency2: rgb=%h blank=%b expected ff4000/1",
               {Red, Green, Blue}, blank_n_o);
    end
  endtask

  task automatic test_colours();
    probe(5, 5, "colour_sprite");
    probe(64, 10, "colour_tile_light");
    probe(64, 64, "colour_tile_dark");
    probe(64, 100, "colour_tile_64_100");
    probe(0, 64, "colour_tile_0_64");
    probe(31, 31, "colour_sprite_edge");
    probe(32, 31, "colour_right_of_sprite");
    blank_n = 1'b0; nextX = 11'd10; nextY = 10'd10;
    step();
    step();
    checks++;
    if ({Red, Green, Blue} !== 24'd0) begin
      failures++;
      $display("[TB] FAIL colour_blanked: got %h expected 000000", {Red, Green, Blue});
    end
  endtask

  task automatic test_strobes();
    logic seq [5];
    seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b1; seq[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hSync_n = seq[i];
      step();
      if (i >= 1) begin
        checks++;
        if (hSync_n_o !== seq[i-1]) begin
          failures++;
          $display("[TB] FAIL hsync_pattern[%0d]: got %b expected %b", i - 1, hSync_n_o, seq[i-1]);
        end
      end
    end
  endtask

  // Random stream, a new pixel and strobe set every clock.
  task automatic test_back_to_back();
    logic [23:0] expRgb [64];
    logic [3:0]  expStr [64];
    logic        b, s, h;
    int          x, y;
    for (int i = 0; i < 64; i++) begin
      b = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      h = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        x = mx + $urandom_range(0, 40) - 4;
        y = my + $urandom_range(0, 40) - 4;
        if (x < 0) x = 0;
        if (y < 0) y = 0;
      end else begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 599);
      end
      blank_n = b; sync_n = s; hSync_n = h; vSync_n = 1'b1;
      nextX = x[10:0]; nextY = y[9:0];
      expRgb[i] = refColour(b, x, y);
      expStr[i] = {b, s, h, 1'b1};
      step();
      if (i >= 1) begin
        checks++;
        if ({Red, Green, Blue} !== expRgb[i-1] ||
            {blank_n_o, sync_n_o, hSync_n_o, vSync_n_o} !== expStr[i-1]) begin
          failures++;
          $display("[TB] FAIL stream[%0d]: rgb=%h strobes=%b expected rgb=%h strobes=%b",
                   i - 1, {Red, Green, Blue}, {blank_n_o, sync_n_o, hSync_n_o, vSync_n_o},
                   expRgb[i-1], expStr[i-1]);
        end
      end
    end
    sync_n = 1'b1; hSync_n = 1'b1;
  endtask

  task automatic test_motion();
    doReset();
    for (int i = 0; i < 5; i++) frameTick(1'b1);
    checks++;
    if (FrameCount !== 16'd5) begin
      failures++;
      $display("[TB] FAIL motion_framecount: got %0d expected 5", FrameCount);
    end
    probe(41, 41, "motion_41_41");
    probe(42, 42, "motion_42_42");
    probe(10, 10, "motion_10_10");
    probe(9, 9, "motion_9_9");
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) frameTick(1'b0);
    checks++;
    if (FrameCount !== 16'd8) begin
      failures++;
      $display("[TB] FAIL freeze_framecount: got %0d expected 8", FrameCount);
    end
    probeSprite("freeze_position");
    for (int i = 0; i < 6; i++) begin
      Run = ~Run;
      step();
    end
    probeSprite("run_toggle_no_tick");
  endtask

  task automatic test_bounce();
    hitRight = 0; hitLeft = 0; hitBottom = 0; hitTop = 0;
    for (int i = 0; i < 1000; i++) begin
      frameTick($urandom_range(0, 15) != 0);
      probeSprite("bounce");
    end
    $display("[TB] bounce coverage: right=%0d left=%0d bottom=%0d top=%0d",
             hitRight, hitLeft, hitBottom, hitTop);
  endtask

  task automatic test_mid_reset();
    blank_n = 1'b1; sync_n = 1'b0; hSync_n = 1'b0;
    nextX = 11'(mx); nextY = 10'(my);
    step();
    step();
    Reset_n = 1'b0;
    step();
    checks++;
    if ({Red, Green, Blue} !== 24'd0 || blank_n_o !== 1'b0 || sync_n_o !== 1'b1 ||
        hSync_n_o !== 1'b1 || vSync_n_o !== 1'b1 || FrameCount !== 16'd0) begin
      failures++;
      $display("[TB] FAIL mid_reset: rgb=%h blank=%b sync=%b h=%b v=%b fc=%0d expected rgb=0 blank=0 syncs=1 fc=0",
               {Red, Green, Blue}, blank_n_o, sync_n_o, hSync_n_o, vSync_n_o, FrameCount);
    end
    Reset_n = 1'b1;
    sync_n = 1'b1; hSync_n = 1'b1;
    modelReset();
    probe(0, 0, "mid_reset_pos_origin");
    probe(32, 0, "mid_reset_pos_right");
    probe(0, 32, "mid_reset_pos_below");
    frameTick(1'b1);
    probeSprite("after_mid_reset_tick");
  endtask

  initial begin
    idleInputs();
    Reset_n = 1'b0;
    modelReset();
    test_reset();
    test_colours();
    test_strobes();
    test_back_to_back();
    test_motion();
    test_freeze();
    test_bounce();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
